// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared load-size encodings for the writeback unit
// Purpose : load-size field type and encodings used by the writeback datapath.
// Contents: load_size_t, LD_WORD, LD_HALF, LD_BYTE (2'b11 is reserved and behaves as word).
package wb_pkg;
  typedef logic [1:0] load_size_t;

  localparam load_size_t LD_WORD = 2'b00;
  localparam load_size_t LD_HALF = 2'b01;
  localparam load_size_t LD_BYTE = 2'b10;
endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - little-endian sub-word load alignment and extension
// Purpose : picks the addressed byte/half lane of a memory word and extends it.
// Ports   : rd_data  in  raw word from data memory
//           offset   in  byte offset within the word (alu_data[1:0])
//           size     in  load size (word / half / byte, reserved = word)
//           uns      in  1 zero-extend, 0 sign-extend
//           data     out aligned, extended word
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rd_data,
  input  logic [1:0]        offset,
  input  load_size_t        size,
  input  logic              uns,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halfword loads ignore offset[0]: a misaligned half reads the enclosing half.
  assign byte_lane = rd_data[{offset, 3'b000} +: 8];
  assign half_lane = rd_data[{offset[1], 4'b0000} +: 16];

  always_comb begin
    data = rd_data;
    case (size)
      LD_BYTE: data = {{(DATA_W-8){~uns & byte_lane[7]}}, byte_lane};
      LD_HALF: data = {{(DATA_W-16){~uns & half_lane[15]}}, half_lane};
      default: data = rd_data;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - MEM/WB pipeline register and register-file write port
// Purpose : captures MEM-stage results, selects ALU vs. aligned load data and gates the
//           register-file write (writes to $0 are always suppressed).
// Ports   : clk, reset (async, active-high), stall, flush, mem_* MEM-stage inputs;
//           wb_valid, reg_write, rd, reg_wr_data register-file outputs;
//           retire_count when WB_RETIRE_COUNT_EN is defined.
// Config  : WB_RETIRE_COUNT_EN adds a wrapping retired-instruction counter.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic [ADDR_W-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0] mem_alu_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  load_size_t        mem_load_size,
  input  logic              mem_load_uns,
  output logic              wb_valid,
  output logic              reg_write,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] reg_wr_data
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [CNT_W-1:0]  retire_count
`endif
);

  logic              valid_q;
  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] alu_data_q;
  logic [DATA_W-1:0] rd_data_q;
  load_size_t        load_size_q;
  logic              load_uns_q;
  logic [DATA_W-1:0] load_data;

  // Flush only kills the slot; the payload fields are don't-care and simply hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      wr_addr_q    <= '0;
      alu_data_q   <= '0;
      rd_data_q    <= '0;
      load_size_q  <= LD_WORD;
      load_uns_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q      <= mem_valid;
      reg_write_q  <= mem_reg_write;
      mem_to_reg_q <= mem_mem_to_reg;
      wr_addr_q    <= mem_wr_addr;
      alu_data_q   <= mem_alu_data;
      rd_data_q    <= mem_rd_data;
      load_size_q  <= mem_load_size;
      load_uns_q   <= mem_load_uns;
    end
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .rd_data (rd_data_q),
    .offset  (alu_data_q[1:0]),
    .size    (load_size_q),
    .uns     (load_uns_q),
    .data    (load_data)
  );

  // A held write during stall re-commits the same value, which is harmless.
  assign wb_valid    = valid_q;
  assign reg_write   = valid_q & reg_write_q & (wr_addr_q != '0);
  assign rd          = wr_addr_q;
  assign reg_wr_data = mem_to_reg_q ? load_data : alu_data_q;

`ifdef WB_RETIRE_COUNT_EN
  logic [CNT_W-1:0] count_q;

  // Counts the slot leaving WB, so a flush of the slot being captured does not matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (valid_q && !stall) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign retire_count = count_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - scoreboard testbench for writeback_unit
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_reg_write = 1'b0;
  logic        mem_mem_to_reg = 1'b0;
  logic [4:0]  mem_wr_addr = '0;
  logic [31:0] mem_alu_data = '0;
  logic [31:0] mem_rd_data = '0;
  logic [1:0]  mem_load_size = '0;
  logic        mem_load_uns = 1'b0;
  logic        wb_valid;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] reg_wr_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  always #5 clk = ~clk;

`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_count;
  logic        model_valid;
  logic [31:0] model_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_valid = 1'b0;
      model_cnt   = 0;
    end else begin
      if (model_valid && !stall) model_cnt = model_cnt + 1;
      if (flush) model_valid = 1'b0;
      else if (!stall) model_valid = mem_valid;
    end
  end
`endif

  writeback_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_wr_addr    (mem_wr_addr),
    .mem_alu_data   (mem_alu_data),
    .mem_rd_data    (mem_rd_data),
    .mem_load_size  (mem_load_size),
    .mem_load_uns   (mem_load_uns),
    .wb_valid       (wb_valid),
    .reg_write      (reg_write),
    .rd             (rd),
    .reg_wr_data    (reg_wr_data)
`ifdef WB_RETIRE_COUNT_EN
    ,
    .retire_count   (retire_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] align_model(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    if (sz == 2'b10) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, wb_valid, e.valid);
    check({tag, "_wr"}, reg_write, e.wr);
    if (e.chk_data) begin
      check({tag, "_rd"}, rd, e.rd);
      check({tag, "_data"}, reg_wr_data, e.data);
    end
`ifdef WB_RETIRE_COUNT_EN
    check({tag, "_cnt"}, retire_count, model_cnt);
`endif
  endtask

  // Drive one cycle of MEM-stage inputs, predict the WB state after the edge, compare.
  task automatic send(input string tag, input logic v, input logic rw, input logic m2r,
                      input logic [4:0] a, input logic [31:0] alu, input logic [31:0] rdd,
                      input logic [1:0] sz, input logic uns, input logic st, input logic fl);
    exp_t e;
    mem_valid = v; mem_reg_write = rw; mem_mem_to_reg = m2r; mem_wr_addr = a;
    mem_alu_data = alu; mem_rd_data = rdd; mem_load_size = sz; mem_load_uns = uns;
    stall = st; flush = fl;
    if (fl) begin
      e = last_exp;
      e.valid = 1'b0;
      e.wr = 1'b0;
      e.chk_data = 1'b0;
    end else if (st) begin
      e = last_exp;
    end else begin
      e.valid = v;
      e.wr = v & rw & (a != 5'd0);
      e.rd = a;
      e.data = m2r ? align_model(rdd, alu[1:0], sz, uns) : alu;
      e.chk_data = 1'b1;
    end
    last_exp = e;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    compare_out(tag);
  endtask

  initial begin
    last_exp = '{valid: 1'b0, wr: 1'b0, rd: 5'd0, data: 32'd0, chk_data: 1'b1};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_valid", wb_valid, 0);
    check("reset_wr", reg_write, 0);
    check("reset_rd", rd, 0);
    check("reset_data", reg_wr_data, 0);
`ifdef WB_RETIRE_COUNT_EN
    check("reset_cnt", retire_count, 0);
`endif

    send("alu",      1, 1, 0, 5'd8,  32'h1234_5678, 32'h0,          2'b00, 0, 0, 0);
    send("lb_o3_s",  1, 1, 1, 5'd9,  32'h0000_1003, 32'h80FF_7F01, 2'b10, 0, 0, 0);
    send("lb_o3_u",  1, 1, 1, 5'd9,  32'h0000_1003, 32'h80FF_7F01, 2'b10, 1, 0, 0);
    send("lb_o1_s",  1, 1, 1, 5'd10, 32'h0000_1001, 32'h80FF_7F01, 2'b10, 0, 0, 0);
    send("lb_o2_s",  1, 1, 1, 5'd10, 32'h0000_1002, 32'h80FF_7F01, 2'b10, 0, 0, 0);
    send("lh_o2_s",  1, 1, 1, 5'd11, 32'h0000_2002, 32'h8001_7FFE, 2'b01, 0, 0, 0);
    send("lh_o0_u",  1, 1, 1, 5'd11, 32'h0000_2000, 32'h8001_7FFE, 2'b01, 1, 0, 0);
    send("lh_o1_s",  1, 1, 1, 5'd11, 32'h0000_2001, 32'h8001_FFFE, 2'b01, 0, 0, 0);
    send("lw",       1, 1, 1, 5'd12, 32'h0000_3002, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
    send("lrsv",     1, 1, 1, 5'd12, 32'h0000_3001, 32'hCAFE_F00D, 2'b11, 1, 0, 0);
    send("r0_write", 1, 1, 0, 5'd0,  32'h5555_AAAA, 32'h0,          2'b00, 0, 0, 0);
    send("no_write", 1, 0, 0, 5'd7,  32'h0BAD_0BAD, 32'h0,          2'b00, 0, 0, 0);
    send("bubble",   0, 1, 0, 5'd7,  32'h7777_7777, 32'h0,          2'b00, 0, 0, 0);

    send("pre_stall", 1, 1, 0, 5'd9, 32'hA5A5_0001, 32'h0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      send($sformatf("stall%0d", i), 1, 1, 1, 5'd3, 32'hFFFF_0000 + i, 32'h1111_1111,
           2'b10, 0, 1, 0);
    send("flush_st", 1, 1, 0, 5'd4, 32'h2222_2222, 32'h0, 2'b00, 0, 1, 1);
    send("post_fl",  1, 1, 0, 5'd5, 32'h3333_3333, 32'h0, 2'b00, 0, 0, 0);

    for (int i = 0; i < 10; i++)
      send($sformatf("rand%0d", i), 1'($urandom), 1'($urandom), 1'($urandom),
           5'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom), 0, 0);

    send("pend_wr", 1, 1, 0, 5'd6, 32'h6666_6666, 32'h0, 2'b00, 0, 0, 0);
    stall = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", wb_valid, 0);
    check("arst_wr", reg_write, 0);
    check("arst_data", reg_wr_data, 0);
`ifdef WB_RETIRE_COUNT_EN
    check("arst_cnt", retire_count, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    last_exp = '{valid: 1'b0, wr: 1'b0, rd: 5'd0, data: 32'd0, chk_data: 1'b1};
    send("after_rst_st", 1, 1, 0, 5'd7, 32'h7, 32'h0, 2'b00, 0, 1, 0);
    send("after_rst",    1, 1, 0, 5'd7, 32'h7, 32'h0, 2'b00, 0, 0, 0);
    send("idle",         0, 0, 0, 5'd0, 32'h0, 32'h0, 2'b00, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
